// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and default baud settings.
// The receiver pulls the same baud constants from here.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;
  localparam int DEFAULT_FIFO_DEPTH   = 4;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_buffered_byte_fifo.sv
// Synchronous byte FIFO with an occupancy count.
// Push into a full FIFO and pop from an empty one are ignored.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter for the console link.
// Bytes queue in a small FIFO; the FSM serialises them LSB first.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] ascii_in,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state;
  uart_state_t   w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_baud_done;
  logic          w_tx;

  assign ready       = !w_full;
  assign w_push      = send && !w_full;
  assign w_baud_done = (r_baud == BAUD_LAST);
  assign tx          = w_tx;
  assign busy        = (r_state != S_IDLE) || (w_count != '0);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (ascii_in),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The head is popped on entry to LOAD, so the FIFO frees a slot
  // in the same edge that ends the previous stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_LOAD;
          w_pop       = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_START;
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_done) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_done && (r_bit == 3'd7)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_state_nxt = S_LOAD;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_pop) begin
        r_shift <= w_head;
      end else if ((r_state == S_DATA) && w_baud_done) begin
        r_shift <= {1'b1, r_shift[7:1]};
      end

      if ((r_state inside {S_START, S_DATA, S_STOP}) && !w_baud_done) begin
        r_baud <= r_baud + BW'(1);
      end else begin
        r_baud <= '0;
      end

      if ((r_state == S_DATA) && w_baud_done) begin
        r_bit <= r_bit + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Stimulus queues expected bytes; a line monitor decodes frames and compares.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .ascii_in(ascii_in),
    .ready   (ready),
    .tx      (tx),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic exp_rdy);
    @(negedge clk);
    check("ready before send", 32'(ready), 32'(exp_rdy));
    send = 1'b1;
    ascii_in = d;
    if (exp_rdy) exp_q.push_back(d);
  endtask

  task automatic release_send();
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_edge,
                           input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 32'(cyc), 32'(exp_edge));
  endtask

  // Line monitor: mid-bit sampling, one decoded frame per scoreboard entry.
  initial begin : monitor
    logic       act;
    int         k;
    int         j;
    logic [7:0] b;
    logic [7:0] e;
    act = 1'b0;
    k = 0;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          k = 0;
        end
      end else begin
        k = k + 1;
      end
      if (rst && act && (k % CPB == CPB / 2)) begin
        j = k / CPB;
        if (j == 0) begin
          check("mon start bit", 32'(tx), 32'd0);
        end else if (j <= 8) begin
          b[j-1] = tx;
        end else begin
          check("mon stop bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon unexpected frame: got %02h expected none", b);
          end else begin
            e = exp_q.pop_front();
            check("mon frame byte", 32'(b), 32'(e));
          end
          act = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    logic saw_low;
    logic [9:0] pat;
    logic exp_b;

    // 1: reset and idle line
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t1 tx reset", 32'(tx), 32'd1);
    check("t1 ready reset", 32'(ready), 32'd1);
    check("t1 busy reset", 32'(busy), 32'd0);
    saw_low = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("t1 idle line", 32'(saw_low), 32'd0);

    // 2: single frame 0x36, exact waveform
    put(8'h36, 1'b1);
    release_send();
    n0 = cyc;
    check("t2 busy after accept", 32'(busy), 32'd1);
    check("t2 tx at N", 32'(tx), 32'd1);
    @(negedge clk);
    check("t2 tx at N+1", 32'(tx), 32'd1);
    pat = 10'b1001101100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("t2 line", 32'(tx), 32'(pat[c/4]));
    end
    check("t2 busy in stop", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2 busy low at N+42", 32'(busy), 32'd0);
    check("t2 end cycle", 32'(cyc - n0), 32'd42);

    // 3: burst of four, back-to-back frames
    put(8'h36, 1'b1);
    put(8'h2B, 1'b1);
    n0 = cyc;
    put(8'h33, 1'b1);
    put(8'h0A, 1'b1);
    release_send();
    wait_idle("t3 busy end", n0 + 165, 300);

    // 4: overflow, sixth byte dropped
    put(8'h41, 1'b1);
    put(8'h42, 1'b1);
    n0 = cyc;
    put(8'h43, 1'b1);
    put(8'h44, 1'b1);
    put(8'h45, 1'b1);
    put(8'h99, 1'b0);
    release_send();
    while (cyc < n0 + 41) @(negedge clk);
    check("t4 ready full before pop", 32'(ready), 32'd0);
    @(negedge clk);
    check("t4 ready after pop", 32'(ready), 32'd1);
    wait_idle("t4 busy end", n0 + 206, 400);

    // 5: reset during d3 of 0x36 with two bytes queued
    put(8'h36, 1'b1);
    put(8'h2B, 1'b1);
    n0 = cyc;
    put(8'h33, 1'b1);
    release_send();
    while (cyc < n0 + 19) @(negedge clk);
    check("t5 tx in d3", 32'(tx), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5 tx after reset", 32'(tx), 32'd1);
    check("t5 ready after reset", 32'(ready), 32'd1);
    check("t5 busy after reset", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("t5 no frames after reset", 32'(saw_low), 32'd0);
    check("t5 busy stays low", 32'(busy), 32'd0);

    // 6: 0x00 then 0xFF, 81-cycle waveform
    put(8'h00, 1'b1);
    put(8'hFF, 1'b1);
    n0 = cyc;
    release_send();
    for (int c = 0; c < 81; c++) begin
      @(negedge clk);
      if (c < 36)      exp_b = 1'b0;
      else if (c < 41) exp_b = 1'b1;
      else if (c < 45) exp_b = 1'b0;
      else             exp_b = 1'b1;
      check("t6 line", 32'(tx), 32'(exp_b));
    end
    wait_idle("t6 busy end", n0 + 83, 20);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
